// File: rtl/osc_wave_render.sv
// Oscilloscope pixel source for the RGB LCD driver (lcd_clk domain).
// Draws a sample trace over a dotted graticule inside a white border. The
// samples live in a double-buffered, one-screen memory that is swapped only
// at frame start.
// Ports:
//   lcd_clk, sys_rst             pixel clock, synchronous active-high reset
//   pixel_xpos/ypos -> pixel_data  coordinate in, RGB565 out 2 cycles later
//   samp_valid/samp_data/samp_ready  sample write handshake into back buffer
//   hold                         freeze display (suppress buffer swaps)
//   frame_swapped                one-cycle pulse when the buffers swap
module osc_wave_render #(
    parameter int unsigned H_VALID    = 800,
    parameter int unsigned V_VALID    = 480,
    parameter int unsigned Y_OFS      = 112,
    parameter int unsigned GRID_SHIFT = 6,
    parameter logic [15:0] COL_BG     = 16'h0000,
    parameter logic [15:0] COL_GRID   = 16'h4208,
    parameter logic [15:0] COL_BORDER = 16'hFFFF,
    parameter logic [15:0] COL_TRACE  = 16'hFFE0
) (
    input  logic        lcd_clk,
    input  logic        sys_rst,
    input  logic [10:0] pixel_xpos,
    input  logic [10:0] pixel_ypos,
    output logic [15:0] pixel_data,
    input  logic        samp_valid,
    input  logic [7:0]  samp_data,
    output logic        samp_ready,
    input  logic        hold,
    output logic        frame_swapped
);
    localparam int unsigned CW = 11;
    localparam int unsigned SW = 8;
    localparam int unsigned AW = $clog2(H_VALID);
    localparam logic [CW-1:0] Y_BASE = CW'(Y_OFS + 255);

    // Sample banks: sel_q = 0 shows mem0 and fills mem1, sel_q = 1 the reverse.
    logic [SW-1:0] mem0_q [H_VALID];
    logic [SW-1:0] mem1_q [H_VALID];

    logic [CW-1:0] ypos_prev_q;
    logic [AW-1:0] wptr_q, wptr_d;
    logic          back_full_q, back_full_d;
    logic          front_valid_q, front_valid_d;
    logic          sel_q, sel_d;
    logic          samp_ready_q;
    logic          frame_swapped_q;

    logic          wr_en_c;
    logic          frame_start_c;
    logic          swap_c;
    logic [AW-1:0] raddr_c;

    // Stage-0 registers (coordinate, read data) and stage-1 history.
    logic [CW-1:0] x1_q, y1_q;
    logic [SW-1:0] rdata_q, sp_q;
    logic          fv1_q;

    logic [SW-1:0] sp_c;
    logic [CW-1:0] ys_c, yp_c, lo_c, hi_c;
    logic [15:0]   pixel_d, pixel_data_q;

    // Write handshake, frame-start detect and swap decision.
    always_comb begin
        wr_en_c       = samp_valid & samp_ready_q & ~sys_rst;
        frame_start_c = (pixel_ypos == '0) && (ypos_prev_q != '0);
        swap_c        = frame_start_c & back_full_q & ~hold;
        wptr_d        = wptr_q;
        back_full_d   = back_full_q;
        front_valid_d = front_valid_q;
        sel_d         = sel_q;
        if (swap_c) begin
            sel_d         = ~sel_q;
            wptr_d        = '0;
            back_full_d   = 1'b0;
            front_valid_d = 1'b1;
        end else if (wr_en_c) begin
            wptr_d = wptr_q + AW'(1);
            if (wptr_q == AW'(H_VALID - 1)) begin
                back_full_d = 1'b1;
            end
        end
    end

    // Control state.
    always_ff @(posedge lcd_clk) begin
        if (sys_rst) begin
            ypos_prev_q     <= '0;
            wptr_q          <= '0;
            back_full_q     <= 1'b0;
            front_valid_q   <= 1'b0;
            sel_q           <= 1'b0;
            samp_ready_q    <= 1'b1;
            frame_swapped_q <= 1'b0;
        end else begin
            ypos_prev_q     <= pixel_ypos;
            wptr_q          <= wptr_d;
            back_full_q     <= back_full_d;
            front_valid_q   <= front_valid_d;
            sel_q           <= sel_d;
            samp_ready_q    <= ~back_full_d;
            frame_swapped_q <= swap_c;
        end
    end

    // Back-buffer write; contents are deliberately not reset.
    always_ff @(posedge lcd_clk) begin
        if (wr_en_c) begin
            if (sel_q) begin
                mem0_q[wptr_q] <= samp_data;
            end else begin
                mem1_q[wptr_q] <= samp_data;
            end
        end
    end

    // Columns past the active area read sample 0 (the pixel is background anyway).
    always_comb begin
        raddr_c = (pixel_xpos < CW'(H_VALID)) ? AW'(pixel_xpos) : '0;
    end

    // Stage 0: the read follows sel_d so a swap shows from the frame-start pixel on.
    always_ff @(posedge lcd_clk) begin
        if (sys_rst) begin
            x1_q         <= '0;
            y1_q         <= '0;
            rdata_q      <= '0;
            sp_q         <= '0;
            fv1_q        <= 1'b0;
            pixel_data_q <= '0;
        end else begin
            x1_q         <= pixel_xpos;
            y1_q         <= pixel_ypos;
            rdata_q      <= sel_d ? mem1_q[raddr_c] : mem0_q[raddr_c];
            sp_q         <= rdata_q;
            fv1_q        <= front_valid_d;
            pixel_data_q <= pixel_d;
        end
    end

    // Stages 1-2: vertical span between adjacent samples, then colour priority.
    always_comb begin
        sp_c = (x1_q == '0) ? rdata_q : sp_q;
        ys_c = Y_BASE - CW'(rdata_q);
        yp_c = Y_BASE - CW'(sp_c);
        lo_c = (ys_c < yp_c) ? ys_c : yp_c;
        hi_c = (ys_c < yp_c) ? yp_c : ys_c;
        pixel_d = COL_BG;
        if (x1_q >= CW'(H_VALID) || y1_q >= CW'(V_VALID)) begin
            pixel_d = COL_BG;
        end else if (fv1_q && y1_q >= lo_c && y1_q <= hi_c) begin
            pixel_d = COL_TRACE;
        end else if (x1_q == '0 || x1_q == CW'(H_VALID - 1) ||
                     y1_q == '0 || y1_q == CW'(V_VALID - 1)) begin
            pixel_d = COL_BORDER;
        end else if (x1_q[GRID_SHIFT-1:0] == '0 && !y1_q[1]) begin
            pixel_d = COL_GRID;
        end else if (y1_q[GRID_SHIFT-1:0] == '0 && !x1_q[1]) begin
            pixel_d = COL_GRID;
        end
    end

    assign pixel_data    = pixel_data_q;
    assign samp_ready    = samp_ready_q;
    assign frame_swapped = frame_swapped_q;
endmodule

// File: tb/tb_osc_wave_render.sv
module tb_osc_wave_render;
    localparam int H = 800;
    localparam int V = 480;

    logic        lcd_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [10:0] pixel_xpos = '0;
    logic [10:0] pixel_ypos = '0;
    logic [15:0] pixel_data;
    logic        samp_valid = 1'b0;
    logic [7:0]  samp_data = '0;
    logic        samp_ready;
    logic        hold = 1'b0;
    logic        frame_swapped;

    osc_wave_render dut (
        .lcd_clk      (lcd_clk),
        .sys_rst      (sys_rst),
        .pixel_xpos   (pixel_xpos),
        .pixel_ypos   (pixel_ypos),
        .pixel_data   (pixel_data),
        .samp_valid   (samp_valid),
        .samp_data    (samp_data),
        .samp_ready   (samp_ready),
        .hold         (hold),
        .frame_swapped(frame_swapped)
    );

    always #5 lcd_clk = ~lcd_clk;

    int checks = 0;
    int failures = 0;

    // Behavioural model: abstract back/front sample lists plus flags.
    int          m_back [H];
    int          m_front[H];
    int          m_count;
    bit          m_full, m_fv;
    int          m_prev_y, m_prev_s;
    bit          armed = 1'b0;
    logic [15:0] p1, p2;
    bit          p1_v, p2_v;
    bit          exp_ready, exp_swapped;
    int          cx, cy, cs, csp;
    bit          cfs, cswap, cwr;
    int          drv_prev_y = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_pixel(input int x, input int y, input bit fv,
                                              input int s, input int sp);
        int ys, yp, lo, hi;
        ys = 367 - s;
        yp = 367 - sp;
        lo = (ys < yp) ? ys : yp;
        hi = (ys < yp) ? yp : ys;
        if (x >= H || y >= V) return 16'h0000;
        if (fv && y >= lo && y <= hi) return 16'hFFE0;
        if (x == 0 || x == H - 1 || y == 0 || y == V - 1) return 16'hFFFF;
        if (x % 64 == 0 && (y / 2) % 2 == 0) return 16'h4208;
        if (y % 64 == 0 && (x / 2) % 2 == 0) return 16'h4208;
        return 16'h0000;
    endfunction

    // Compare against the model, then advance the model with this cycle's inputs.
    always @(negedge lcd_clk) begin
        if (armed) begin
            check("samp_ready", {15'd0, samp_ready}, {15'd0, exp_ready});
            check("frame_swapped", {15'd0, frame_swapped}, {15'd0, exp_swapped});
            if (p2_v) check("pixel_data", pixel_data, p2);
        end
        if (sys_rst) begin
            armed       = 1'b1;
            m_count     = 0;
            m_full      = 1'b0;
            m_fv        = 1'b0;
            m_prev_y    = 0;
            m_prev_s    = 0;
            exp_ready   = 1'b1;
            exp_swapped = 1'b0;
            p2          = 16'h0000;
            p2_v        = 1'b1;
            p1_v        = 1'b0;
        end else if (armed) begin
            cx    = int'(pixel_xpos);
            cy    = int'(pixel_ypos);
            cfs   = (cy == 0) && (m_prev_y != 0);
            cswap = cfs && m_full && !hold;
            cwr   = samp_valid && !m_full;
            if (cswap) begin
                m_front = m_back;
                m_count = 0;
                m_full  = 1'b0;
                m_fv    = 1'b1;
            end else if (cwr) begin
                m_back[m_count] = int'(samp_data);
                m_count++;
                if (m_count == H) m_full = 1'b1;
            end
            cs   = m_front[(cx < H) ? cx : 0];
            csp  = (cx == 0) ? cs : m_prev_s;
            p2   = p1;
            p2_v = p1_v;
            p1   = ref_pixel(cx, cy, m_fv, cs, csp);
            p1_v = 1'b1;
            m_prev_s    = cs;
            m_prev_y    = cy;
            exp_ready   = !m_full;
            exp_swapped = cswap;
        end
    end

    // A frame start at a nonzero column would expose the unknown old sp, so
    // the driver always enters line 0 at column 0 like a real scan does.
    task automatic set_xy(input int x, input int y);
        pixel_xpos = (y == 0 && drv_prev_y != 0) ? 11'd0 : 11'(x);
        pixel_ypos = 11'(y);
    endtask

    task automatic tick();
        drv_prev_y = sys_rst ? 0 : int'(pixel_ypos);
        @(posedge lcd_clk);
        #1;
    endtask

    task automatic probe(input string name, input int x, input int y, input logic [15:0] exp);
        set_xy(x, y);
        tick();
        tick();
        check(name, pixel_data, exp);
    endtask

    // Coordinate (0,y) then (1,y): column 1 joins sample 1 to sample 0.
    task automatic probe_col1(input string name, input int y, input logic [15:0] exp);
        set_xy(0, y);
        tick();
        set_xy(1, y);
        tick();
        tick();
        check(name, pixel_data, exp);
    endtask

    function automatic logic [7:0] gen(input int mode, input int i);
        if (mode == 0) return 8'h80;
        if (mode == 1) return (i % 2 == 0) ? 8'h00 : 8'hFF;
        return 8'($urandom);
    endfunction

    task automatic fill(input int mode, input int n);
        for (int i = 0; i < n; i++) begin
            samp_valid = 1'b1;
            samp_data  = gen(mode, i);
            set_xy(i % H, 5);
            tick();
        end
        samp_valid = 1'b0;
    endtask

    task automatic frame_start(input string name, input bit exp_sw);
        set_xy(5, 1);
        tick();
        set_xy(0, 0);
        tick();
        check(name, {15'd0, frame_swapped}, {15'd0, exp_sw});
        set_xy(1, 0);
        tick();
        check({name, "_end"}, {15'd0, frame_swapped}, 16'd0);
    endtask

    task automatic scan_line(input int y);
        for (int x = 0; x < H; x++) begin
            set_xy(x, y);
            tick();
        end
    endtask

    task automatic random_render(input int n);
        for (int i = 0; i < n; i++) begin
            set_xy($urandom_range(0, 900), $urandom_range(100, 380));
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < H; i++) begin
            m_back[i]  = 0;
            m_front[i] = 0;
        end
        sys_rst = 1'b1;
        set_xy(0, 0);
        repeat (3) tick();
        sys_rst = 1'b0;
        check("rst_pixel", pixel_data, 16'h0000);
        check("rst_ready", {15'd0, samp_ready}, 16'd1);
        check("rst_swapped", {15'd0, frame_swapped}, 16'd0);

        // Empty display: border and graticule only.
        probe("p_0_0", 0, 0, 16'hFFFF);
        probe("p_64_0", 64, 0, 16'hFFFF);
        probe("p_64_8", 64, 8, 16'h4208);
        probe("p_64_10", 64, 10, 16'h0000);
        probe("p_5_5", 5, 5, 16'h0000);
        scan_line(239);

        // Flat 0x80 trace at line 239, with ignored extra samples.
        fill(0, H);
        check("full_ready", {15'd0, samp_ready}, 16'd0);
        samp_valid = 1'b1;
        samp_data  = 8'h00;
        repeat (3) tick();
        samp_valid = 1'b0;
        frame_start("swap_flat", 1'b1);
        scan_line(239);
        probe("flat_400_239", 400, 239, 16'hFFE0);
        probe("flat_400_238", 400, 238, 16'h0000);

        // Alternating 0x00/0xFF: column 1 spans lines 112..367.
        fill(1, H);
        frame_start("swap_alt", 1'b1);
        probe_col1("alt_1_111", 111, 16'h0000);
        probe_col1("alt_1_112", 112, 16'hFFE0);
        probe_col1("alt_1_240", 240, 16'hFFE0);
        probe_col1("alt_1_367", 367, 16'hFFE0);
        probe_col1("alt_1_368", 368, 16'h0000);

        // Hold with a full back buffer across three frame starts.
        fill(2, H);
        hold = 1'b1;
        for (int k = 0; k < 3; k++) frame_start("hold_no_swap", 1'b0);
        check("hold_ready", {15'd0, samp_ready}, 16'd0);
        hold = 1'b0;
        frame_start("hold_release", 1'b1);
        random_render(1000);

        // Last write coincident with frame start delays the swap one frame.
        fill(2, H - 1);
        set_xy(5, 1);
        tick();
        samp_valid = 1'b1;
        samp_data  = 8'h3C;
        set_xy(0, 0);
        tick();
        check("coincident_no_swap", {15'd0, frame_swapped}, 16'd0);
        check("coincident_full", {15'd0, samp_ready}, 16'd0);
        samp_data = 8'hC3;
        set_xy(1, 0);
        repeat (4) tick();
        samp_valid = 1'b0;
        frame_start("delayed_swap", 1'b1);
        set_xy(799, 307);
        tick();
        probe("last_799_307", 799, 307, 16'hFFE0);
        probe("last_799_306", 799, 306, 16'hFFFF);
        random_render(1000);

        // Reset mid-frame: trace gone until a fresh fill and swap.
        set_xy(300, 200);
        tick();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        check("mid_rst_pixel", pixel_data, 16'h0000);
        check("mid_rst_ready", {15'd0, samp_ready}, 16'd1);
        random_render(500);
        probe("mid_rst_400_239", 400, 239, 16'h0000);
        fill(0, H);
        frame_start("swap_after_rst", 1'b1);
        probe("after_rst_400_239", 400, 239, 16'hFFE0);

        // Random traffic: samples, holds, frame starts, occasional reset.
        for (int c = 0; c < 20000; c++) begin
            samp_valid = 1'($urandom_range(0, 1));
            samp_data  = 8'($urandom);
            if ($urandom_range(0, 499) == 0) hold = ~hold;
            sys_rst = ($urandom_range(0, 3999) == 0);
            set_xy($urandom_range(0, 900),
                   ($urandom_range(0, 63) == 0) ? 0 : $urandom_range(1, 520));
            tick();
        end
        sys_rst    = 1'b0;
        samp_valid = 1'b0;
        hold       = 1'b0;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
